// File: rtl/id_ctrl_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ctrl_stage_pkg
// Shared definitions for the decode/control stage: 5-bit opcode constants,
// the decoded control-bit bundle, and the halt state machine encoding.
// -----------------------------------------------------------------------------
package id_ctrl_stage_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_HALT = 5'b00000;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b10000;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b10001;
    localparam logic [OPC_W-1:0] OP_STU  = 5'b10011;

    // Register-register ALU group: second ALU operand comes from rs2.
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b11011;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b11100;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b11101;
    localparam logic [OPC_W-1:0] OP_SLT  = 5'b11110;
    localparam logic [OPC_W-1:0] OP_SLE  = 5'b11111;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_HALTED    = 2'd2
    } state_e;

    typedef struct packed {
        logic alu_src2;
        logic mem_wr;
        logic mem_rd;
        logic halt;
    } ctrl_t;

endpackage

// File: rtl/id_opcode_decode.sv
// -----------------------------------------------------------------------------
// id_opcode_decode
// Purely combinational map from a 5-bit opcode to execute-side control bits.
// Opcodes not listed decode to all-zero control.
//   opcode_i : opcode field of the instruction
//   ctrl_o   : {alu_src2, mem_wr, mem_rd, halt}
// -----------------------------------------------------------------------------
module id_opcode_decode
    import id_ctrl_stage_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output ctrl_t            ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND,
            OP_OR,  OP_SLT, OP_SLE: ctrl_o.alu_src2 = 1'b1;
            OP_ST,  OP_STU:         ctrl_o.mem_wr   = 1'b1;
            OP_LD:                  ctrl_o.mem_rd   = 1'b1;
            OP_HALT:                ctrl_o.halt     = 1'b1;
            default:                ;
        endcase
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// -----------------------------------------------------------------------------
// id_ctrl_stage
// Registered decode/control stage between fetch and execute. One instruction
// per cycle over valid/ready; the instruction and its decoded control bits are
// held in a single pipeline register. Includes flush, a sticky halt state
// machine and a saturating count of accepted instructions.
// PAYLOAD_W must be at least 5 (opcode is the top 5 bits of in_instr).
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : drop the held entry and anything offered this cycle
//   in_valid/in_ready/in_instr   : upstream handshake and instruction
//   out_valid/out_ready/out_instr: downstream handshake and held instruction
//   out_alu_src2, out_mem_wr, out_mem_rd, out_halt : registered control bits
//   halted        : sticky, set when the halt instruction has been consumed
//   dec_count     : accepted-instruction count, saturating
// -----------------------------------------------------------------------------
module id_ctrl_stage
    import id_ctrl_stage_pkg::*;
#(
    parameter int PAYLOAD_W = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_instr,
    output logic                 out_alu_src2,
    output logic                 out_mem_wr,
    output logic                 out_mem_rd,
    output logic                 out_halt,
    output logic                 halted,
    output logic [CNT_W-1:0]     dec_count
);

    state_e                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [PAYLOAD_W-1:0]  instr_q;
    ctrl_t                 ctrl_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    ctrl_t                 dec_ctrl;
    logic                  acc;
    logic                  pop;

    id_opcode_decode u_dec (
        .opcode_i (in_instr[PAYLOAD_W-1 -: OPC_W]),
        .ctrl_o   (dec_ctrl)
    );

    // Ready is independent of in_valid and flush so upstream never sees a
    // combinational loop through its own valid.
    assign in_ready = (state_q == ST_RUN) && (!valid_q || out_ready);
    assign acc      = in_valid && in_ready && !flush;
    assign pop      = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_RUN: begin
                if (flush) begin
                    valid_d = 1'b0;
                end else if (acc) begin
                    valid_d = 1'b1;
                    if (dec_ctrl.halt) state_d = ST_HALT_PEND;
                end else if (pop) begin
                    valid_d = 1'b0;
                end
            end
            ST_HALT_PEND: begin
                // The held entry is the halt; a pop wins over a same-cycle flush.
                if (pop) begin
                    state_d = ST_HALTED;
                    valid_d = 1'b0;
                end else if (flush) begin
                    state_d = ST_RUN;
                    valid_d = 1'b0;
                end
            end
            ST_HALTED: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
                valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (acc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            instr_q <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            // Payload only moves on accept; otherwise it holds its last value.
            if (acc) begin
                instr_q <= in_instr;
                ctrl_q  <= dec_ctrl;
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_instr    = instr_q;
    assign out_alu_src2 = ctrl_q.alu_src2;
    assign out_mem_wr   = ctrl_q.mem_wr;
    assign out_mem_rd   = ctrl_q.mem_rd;
    assign out_halt     = ctrl_q.halt;
    assign halted       = (state_q == ST_HALTED);
    assign dec_count    = cnt_q;

endmodule

// File: doc/id_ctrl_stage.md
Name: id_ctrl_stage

Overview:
Registered decode/control stage between fetch and execute. Accepts one instruction per cycle over a valid/ready handshake. Decodes the 5-bit opcode into execute-side control bits (alu_src2, mem_wr, mem_rd, halt) and holds them with the instruction in one pipeline register. Adds stall back-pressure, flush, a sticky halt state machine and a saturating decoded-instruction counter.

Parameters:
PAYLOAD_W, 16, instruction width; opcode = in_instr[PAYLOAD_W-1 -: 5]; must be >= 5
CNT_W, 16, width of dec_count

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
flush  input  1  discard the held entry and any entry offered this cycle
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage accepts in_instr this cycle
in_instr  input  PAYLOAD_W  instruction word
out_valid  output  1  held entry valid
out_ready  input  1  downstream consumes the held entry
out_instr  output  PAYLOAD_W  registered instruction
out_alu_src2  output  1  registered: opcode in {11010,11011,11100,11101,11110,11111}
out_mem_wr  output  1  registered: opcode in {10000,10011}
out_mem_rd  output  1  registered: opcode == 10001
out_halt  output  1  registered: opcode == 00000
halted  output  1  sticky halt-complete flag
dec_count  output  CNT_W  number of accepted instructions, saturating

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out_instr=0, all control outputs 0, state=RUN, halted=0, dec_count=0. Reset overrides flush and handshake.
- Accept: acc = in_valid & in_ready & ~flush. in_ready = (state==RUN) & (~out_valid | out_ready). in_ready is combinational and does not depend on in_valid or flush.
- On acc, next cycle: out_valid=1, out_instr=in_instr, control bits decoded from the opcode. Latency is 1 cycle. Opcodes outside the listed sets produce all-zero control bits.
- Pop: pop = out_valid & out_ready. Pop without acc clears out_valid. Pop with acc refills in the same edge, giving full throughput. Hold (out_valid & ~out_ready) keeps all outputs stable.
- Control outputs are don't-care when out_valid=0. The implementation holds their last value; the bench does not check them in that case.
- flush=1: next cycle out_valid=0 and no accept occurs. dec_count is not incremented for anything offered during a flush cycle.
- State machine:
  - RUN: on acc of an opcode of 00000, go to HALT_PEND.
  - HALT_PEND: in_ready=0. On pop of the halt entry, go to HALTED and set halted=1 in the same edge. On flush before the pop, drop the entry and return to RUN; halted stays 0.
  - HALTED: in_ready=0 and out_valid=0 permanently. flush has no effect. Exit only via rst.
- A simultaneous pop and flush in HALT_PEND counts as a pop: the halt retires and the state goes to HALTED.
- dec_count increments by 1 on each acc and saturates at 2^CNT_W-1 with no wrap. Flushed entries are not subtracted.
- No combinational path from in_* to out_*; only in_ready depends on out_ready.

Decomposition:
- Shared package/include: 5-bit opcode constants (OP_HALT=00000, OP_ST=10000, OP_LD=10001, OP_STU=10011, OP_ADD..OP_SLE rr group 11010-11111) and the state encoding (RUN=2'd0, HALT_PEND=2'd1, HALTED=2'd2).
- One sub-module, id_opcode_decode: purely combinational opcode-to-control-bits map. The stage registers its outputs.

Test Plan:
- Stream 11011, 10000, 10001, 01000 with out_ready=1 held. Each appears 1 cycle after accept with (alu_src2,mem_wr,mem_rd) = 100, 010, 001, 000. dec_count=4.
- Accept 11100, then hold out_ready=0 for 3 cycles while in_valid=1 with 10011. in_ready=0 and outputs are stable for 3 cycles. On release, 11100 pops and 10011 is accepted in the same edge.
- Entry held, then flush=1 with in_valid=1 and opcode 11111 offered. Next cycle out_valid=0, nothing is accepted, dec_count is unchanged.
- Accept 00000 with out_ready=0 for 2 cycles, then 1. in_ready=0 from the cycle after acceptance. halted=1 after the pop. A later in_valid is never accepted and out_valid stays 0.
- Accept 00000, then flush before the pop. State returns to RUN, halted=0, and 11010 is accepted next with out_alu_src2=1.
- CNT_W=3: accept 9 instructions, so dec_count saturates at 7. Assert rst mid-stream with out_valid=1: all outputs 0 on the next cycle and state=RUN.
